neuron_output_stage: RTL and testbench
======================================

# neuron_output_stage

Post-accumulation stage sitting directly downstream of the pipelined multiply-accumulate unit. It waits for the MAC's `done` and lets the multiplier pipeline drain, then captures the sfix26_En18 sum and adds a per-neuron bias. It applies optional ReLU, then rounds and saturates to a signed integer pixel for the next layer. Results are queued in a small FIFO with valid/ready output. The block also owns the MAC's reset, re-arming it for the next neuron once the current result is stored.

## Interface
- `ACC_WIDTH`, 26: accumulator/bias width, sfix26_En18.
- `FRAC_BITS`, 18: fractional bits of `acc_in`/`bias_in`.
- `OUT_WIDTH`, 8: output pixel width, signed integer (sfixOUT_WIDTH_En0).
- `MULT_LATENCY`, 2: multiplier pipeline depth; must be ≥1.
- `FIFO_DEPTH`, 4: result FIFO entries; power of two, ≥2.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `acc_in`  in  ACC_WIDTH  MAC running sum (MAC `OUT`).
- `acc_done`  in  1  MAC `done`; level, held high until the MAC is reset.
- `bias_in`  in  ACC_WIDTH  bias, sfix26_En18; sampled together with `acc_in`.
- `relu_en`  in  1  1 = clamp negative sums to 0; sampled with `acc_in`.
- `mac_rst`  out  1  reset to the MAC.
- `out_pixel`  out  OUT_WIDTH  FIFO head data.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts head when high with `out_valid`.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  entries held.
- `sat_flag`  out  1  sticky; set on any saturation.

## Operation
- FSM states and transitions:
  - CLEAR: `mac_rst`=1 for 1 cycle → RUN.
  - RUN: wait for `acc_done`=1 → SETTLE, with counter = MULT_LATENCY.
  - SETTLE: decrement the counter each cycle. On the last cycle (counter==1), register `sum = sext(acc_in)+sext(bias_in)` at ACC_WIDTH+1 bits, plus `relu_en` → PROCESS.
  - PROCESS: if the FIFO is not full, push the result → CLEAR. Otherwise stay in PROCESS (backpressure). The MAC is not reset while stalled; it holds its sum because it accumulates zero products after `done`.
- `mac_rst = rst | (state==CLEAR)`.
- Result arithmetic:
  - If `relu_en` and sum<0, sum = 0.
  - Round half-up: add 2^(FRAC_BITS-1), then arithmetic shift right by FRAC_BITS.
  - Saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - Saturation sets `sat_flag`.
- FIFO:
  - Pop on `out_valid & out_ready`.
  - Push only when not full at cycle start. A simultaneous pop does not free space for a same-cycle push.
  - Simultaneous push and pop when non-empty and not full leaves the level unchanged.
- Reset values: state=CLEAR (so `mac_rst`=1 during `rst` and on the first cycle after release), FIFO empty, `out_valid`=0, `out_pixel`=0, `fifo_level`=0, `sat_flag`=0.
- Reset mid-operation discards any captured sum and all FIFO contents.

## Timing
- Let D be the first cycle with `acc_done`=1 in RUN, and L = MULT_LATENCY.
- The sum is captured at the end of cycle D+L; it samples `acc_in` as seen during cycle D+L.
- PROCESS is cycle D+L+1. The push occurs at the end of that cycle.
- `out_valid`=1 and `out_pixel` valid from cycle D+L+2, with an empty FIFO and no stall.
- CLEAR (`mac_rst`=1) is cycle D+L+2; RUN resumes at D+L+3.
- Throughput is one result per (MAC run + L+3) cycles.
- `out_pixel` changes only on a pop or when pushing into an empty FIFO.

## Structure
- Shared package `nn_fixed_pkg`: ACC_WIDTH, FRAC_BITS, PIXEL/OUT widths, state enum, and a round/saturate function.
- Sub-module `sync_fifo` (parameterised width/depth, level output). FSM and arithmetic stay in the top module.

## Test plan
- `acc_in`=3.0 (0x0C0000), `bias_in`=0.5 (0x020000), relu on → `out_pixel`=4 at D+L+2; `mac_rst` pulses at D+L+2.
- `acc_in`=-2.0: relu on → 0; relu off → 0xFE (-2). With `acc_in`=-2.5, relu off → 0xFE (half-up rounding).
- `acc_in`=100.0, `bias_in`=50.0 → 0x7F and `sat_flag`=1. `acc_in`=-100.0, `bias_in`=-50.0, relu off → 0x80. Flag stays high until `rst`.
- `out_ready`=0, five neurons with values 1..5 → level 4, FSM stalls in PROCESS, `mac_rst` stays low. Then `out_ready`=1 → outputs 1,2,3,4,5 in order; fifth pushed the cycle after the first pop.
- `rst` asserted during SETTLE → no push, FIFO empty, `mac_rst`=1 through reset and one cycle after; the next neuron is processed normally.
- Same-cycle pop and push with level 2 → level stays 2, order preserved.

Source files
------------

// File: rtl/nn_fixed_pkg.sv
// Shared fixed-point constants, FSM state encoding and the round/saturate helper
// used by the post-accumulation stage of the neuron datapath.
package nn_fixed_pkg;

  localparam int ACC_WIDTH   = 26;
  localparam int FRAC_BITS   = 18;
  localparam int OUT_WIDTH   = 8;
  localparam int PIXEL_WIDTH = OUT_WIDTH;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_RUN,
    ST_SETTLE,
    ST_PROCESS
  } state_t;

  typedef struct packed {
    logic signed [63:0] value;
    logic               sat;
  } round_sat_t;

  // Round half-up to an integer, then clamp to a signed out_width-bit range.
  function automatic round_sat_t round_sat(input logic signed [63:0] sum,
                                           input int frac_bits,
                                           input int out_width);
    logic signed [63:0] rounded;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    round_sat_t         res;
    rounded   = (sum + (64'sd1 <<< (frac_bits - 1))) >>> frac_bits;
    max_v     = (64'sd1 <<< (out_width - 1)) - 64'sd1;
    min_v     = -(64'sd1 <<< (out_width - 1));
    res.value = rounded;
    res.sat   = 1'b0;
    if (rounded > max_v) begin
      res.value = max_v;
      res.sat   = 1'b1;
    end else if (rounded < min_v) begin
      res.value = min_v;
      res.sat   = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with level output; a push is accepted only when not full at
// cycle start, so a same-cycle pop never makes room for it.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_valid,
  output logic                       o_full,
  output logic [$clog2(DEPTH):0]     o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_level == LW'(DEPTH));
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && (r_level != '0);

  // NOTE: sequential state is written with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= r_level + LW'(w_push_ok) - LW'(w_pop_ok);
    end
  end

  // NOTE: the storage array is deliberately not reset; the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = (r_level == '0) ? '0 : r_mem[r_rd_ptr];
  assign o_valid = (r_level != '0);
  assign o_level = r_level;

endmodule

// File: rtl/neuron_output_stage.sv
// Captures the MAC sum after the multiplier drains, adds bias, applies optional
// ReLU, rounds/saturates to a pixel and queues it; also re-arms the MAC.
module neuron_output_stage
  import nn_fixed_pkg::*;
#(
  parameter int ACC_WIDTH    = nn_fixed_pkg::ACC_WIDTH,
  parameter int FRAC_BITS    = nn_fixed_pkg::FRAC_BITS,
  parameter int OUT_WIDTH    = nn_fixed_pkg::OUT_WIDTH,
  parameter int MULT_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ACC_WIDTH-1:0]          acc_in,
  input  logic                          acc_done,
  input  logic [ACC_WIDTH-1:0]          bias_in,
  input  logic                          relu_en,
  output logic                          mac_rst,
  output logic [OUT_WIDTH-1:0]          out_pixel,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          sat_flag
);

  localparam int CNT_W = $clog2(MULT_LATENCY + 1);

  state_t                    r_state;
  logic [CNT_W-1:0]          r_cnt;
  logic signed [ACC_WIDTH:0] r_sum;
  logic                      r_relu;
  logic                      r_sat_flag;
  logic signed [ACC_WIDTH:0] w_relu_sum;
  round_sat_t                w_res;
  logic [OUT_WIDTH-1:0]      w_pixel;
  logic                      w_full;
  logic                      w_push;
  logic                      w_unused;

  // NOTE: each always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_relu_sum = r_sum;
    if (r_relu && r_sum[ACC_WIDTH]) w_relu_sum = '0;
    w_res   = round_sat(64'(w_relu_sum), FRAC_BITS, OUT_WIDTH);
    w_pixel = w_res.value[OUT_WIDTH-1:0];
  end

  // Upper bits of the clamped value are sign copies of the pixel.
  assign w_unused = ^w_res.value[63:OUT_WIDTH];

  assign w_push   = (r_state == ST_PROCESS) && !w_full;
  assign mac_rst  = rst | (r_state == ST_CLEAR);
  assign sat_flag = r_sat_flag;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_CLEAR;
      r_cnt      <= '0;
      r_sum      <= '0;
      r_relu     <= 1'b0;
      r_sat_flag <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: r_state <= ST_RUN;
        ST_RUN: begin
          if (acc_done) begin
            r_state <= ST_SETTLE;
            r_cnt   <= CNT_W'(MULT_LATENCY);
          end
        end
        ST_SETTLE: begin
          r_cnt <= r_cnt - CNT_W'(1);
          // Last drain cycle: the MAC output now includes the final product.
          if (r_cnt == CNT_W'(1)) begin
            r_sum   <= {acc_in[ACC_WIDTH-1], acc_in} + {bias_in[ACC_WIDTH-1], bias_in};
            r_relu  <= relu_en;
            r_state <= ST_PROCESS;
          end
        end
        ST_PROCESS: begin
          if (w_push) begin
            r_state    <= ST_CLEAR;
            r_sat_flag <= r_sat_flag | w_res.sat;
          end
        end
        default: r_state <= ST_CLEAR;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_pixel),
    .i_pop   (out_ready),
    .o_data  (out_pixel),
    .o_valid (out_valid),
    .o_full  (w_full),
    .o_level (fifo_level)
  );

endmodule

// File: tb/tb_neuron_output_stage.sv
// Scoreboard bench for neuron_output_stage: expected pixels are queued when a
// neuron is driven and compared whenever the DUT hands one over.
module tb_neuron_output_stage;

  localparam int     L   = 2;
  localparam longint ONE = 262144;

  logic        clk = 1'b0;
  logic        rst;
  logic [25:0] acc_in;
  logic        acc_done;
  logic [25:0] bias_in;
  logic        relu_en;
  logic        mac_rst;
  logic [7:0]  out_pixel;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  fifo_level;
  logic        sat_flag;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];

  neuron_output_stage #(
    .ACC_WIDTH    (26),
    .FRAC_BITS    (18),
    .OUT_WIDTH    (8),
    .MULT_LATENCY (L),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .acc_in     (acc_in),
    .acc_done   (acc_done),
    .bias_in    (bias_in),
    .relu_en    (relu_en),
    .mac_rst    (mac_rst),
    .out_pixel  (out_pixel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fifo_level (fifo_level),
    .sat_flag   (sat_flag)
  );

  always #5 clk = ~clk;

  // Scoreboard: a handshake seen at the negedge completes at the next posedge.
  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL pixel_unexpected: got %h, none expected", out_pixel);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (out_pixel !== e) begin
          n_err++;
          $display("FAIL pixel: got %h, expected %h", out_pixel, e);
        end
      end
    end
  end

  function automatic logic [7:0] model_pixel(input longint acc, input longint bias, input bit relu);
    real    v;
    longint q;
    v = real'(acc + bias) / 262144.0;
    if (relu && v < 0.0) v = 0.0;
    v = $floor(v + 0.5);
    if (v > 127.0)  v = 127.0;
    if (v < -128.0) v = -128.0;
    q = longint'(v);
    return q[7:0];
  endfunction

  // Entered and left at posedge+1 with the FSM in RUN; exp_lat<0 skips timing checks.
  task automatic run_neuron(input longint acc, input longint bias, input bit relu,
                            input logic [7:0] exp_pix, input int exp_lat);
    int lat;
    bit seen;
    acc_in   = acc[25:0];
    bias_in  = bias[25:0];
    relu_en  = relu;
    acc_done = 1'b1;
    exp_q.push_back(exp_pix);
    seen = 1'b0;
    lat  = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (mac_rst === 1'b1) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    if (!seen) begin
      n_vec++; n_err++;
      $display("FAIL neuron_timeout: mac_rst not seen within 200 cycles, expected at %0d", exp_lat);
    end else if (exp_lat >= 0) begin
      n_vec++;
      if (lat != exp_lat) begin
        n_err++;
        $display("FAIL mac_rst_latency: got %0d, expected %0d", lat, exp_lat);
      end
      n_vec++;
      if (out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL out_valid_latency: got %b, expected 1", out_valid);
      end
    end
    @(posedge clk); #1;
    acc_done = 1'b0;
  endtask

  task automatic drain();
    bit emptied;
    out_ready = 1'b1;
    emptied = 1'b0;
    for (int i = 0; i < 40 && !emptied; i++) begin
      @(negedge clk);
      if (out_valid === 1'b0) emptied = 1'b1;
    end
    n_vec++;
    if (!emptied || exp_q.size() != 0 || fifo_level !== 3'd0) begin
      n_err++;
      $display("FAIL drain: level %0d, %0d pending, expected level 0, 0 pending", fifo_level, exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    acc_done = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      n_vec++;
      if (mac_rst !== 1'b1 || fifo_level !== 3'd0 || out_valid !== 1'b0 || out_pixel !== 8'd0) begin
        n_err++;
        $display("FAIL in_reset: mac_rst %b level %0d valid %b pixel %h, expected 1 0 0 00",
                 mac_rst, fifo_level, out_valid, out_pixel);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (mac_rst !== 1'b1) begin
      n_err++;
      $display("FAIL mac_rst_after_release: got %b, expected 1", mac_rst);
    end
    @(negedge clk);
    n_vec++;
    if (mac_rst !== 1'b0) begin
      n_err++;
      $display("FAIL mac_rst_run: got %b, expected 0", mac_rst);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset(3);
    n_vec++;
    if (sat_flag !== 1'b0) begin
      n_err++;
      $display("FAIL reset_sat_flag: got %b, expected 0", sat_flag);
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    run_neuron(3 * ONE, ONE / 2, 1'b1, 8'd4, L + 2);
    run_neuron(ONE / 2, 0, 1'b0, 8'd1, L + 2);
    n_vec++;
    if (sat_flag !== 1'b0 || fifo_level !== 3'd0) begin
      n_err++;
      $display("FAIL basic_state: sat %b level %0d, expected 0 0", sat_flag, fifo_level);
    end
  endtask

  task automatic test_relu_round();
    out_ready = 1'b1;
    run_neuron(-2 * ONE, 0, 1'b1, 8'h00, L + 2);
    run_neuron(-2 * ONE, 0, 1'b0, 8'hFE, L + 2);
    run_neuron(-5 * ONE / 2, 0, 1'b0, 8'hFE, L + 2);
    run_neuron(-ONE / 2, 0, 1'b0, 8'h00, L + 2);
    for (int i = 0; i < 6; i++) begin
      longint a;
      longint b;
      bit     r;
      a = longint'($urandom_range(0, 80 * 262144)) - 40 * ONE;
      b = longint'($urandom_range(0, 8 * 262144)) - 4 * ONE;
      r = 1'($urandom_range(0, 1));
      run_neuron(a, b, r, model_pixel(a, b, r), L + 2);
    end
  endtask

  task automatic test_saturation();
    out_ready = 1'b1;
    n_vec++;
    if (sat_flag !== 1'b0) begin
      n_err++;
      $display("FAIL sat_before: got %b, expected 0", sat_flag);
    end
    run_neuron(100 * ONE, 50 * ONE, 1'b0, 8'h7F, L + 2);
    n_vec++;
    if (sat_flag !== 1'b1) begin
      n_err++;
      $display("FAIL sat_pos: got %b, expected 1", sat_flag);
    end
    run_neuron(-100 * ONE, -50 * ONE, 1'b0, 8'h80, L + 2);
    run_neuron(ONE, 0, 1'b0, 8'd1, L + 2);
    n_vec++;
    if (sat_flag !== 1'b1) begin
      n_err++;
      $display("FAIL sat_sticky: got %b, expected 1", sat_flag);
    end
    do_reset(2);
    n_vec++;
    if (sat_flag !== 1'b0) begin
      n_err++;
      $display("FAIL sat_cleared: got %b, expected 0", sat_flag);
    end
  endtask

  task automatic test_backpressure();
    bit stalled_ok;
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) run_neuron(longint'(i) * ONE, 0, 1'b1, 8'(i), L + 2);
    acc_in   = 26'(5 * ONE);
    bias_in  = '0;
    relu_en  = 1'b1;
    acc_done = 1'b1;
    exp_q.push_back(8'd5);
    stalled_ok = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (mac_rst !== 1'b0) stalled_ok = 1'b0;
    end
    n_vec++;
    if (!stalled_ok || fifo_level !== 3'd4) begin
      n_err++;
      $display("FAIL stall: mac_rst_low %b level %0d, expected 1 4", stalled_ok, fifo_level);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (fifo_level !== 3'd4 || mac_rst !== 1'b0) begin
      n_err++;
      $display("FAIL first_pop_cycle: level %0d mac_rst %b, expected 4 0", fifo_level, mac_rst);
    end
    @(negedge clk);
    n_vec++;
    if (fifo_level !== 3'd3 || mac_rst !== 1'b0) begin
      n_err++;
      $display("FAIL fifth_push_cycle: level %0d mac_rst %b, expected 3 0", fifo_level, mac_rst);
    end
    @(negedge clk);
    n_vec++;
    if (fifo_level !== 3'd3 || mac_rst !== 1'b1) begin
      n_err++;
      $display("FAIL after_fifth_push: level %0d mac_rst %b, expected 3 1", fifo_level, mac_rst);
    end
    @(posedge clk); #1;
    acc_done = 1'b0;
    drain();
  endtask

  task automatic test_reset_settle();
    out_ready = 1'b1;
    acc_in   = 26'(7 * ONE);
    bias_in  = '0;
    relu_en  = 1'b0;
    acc_done = 1'b1;
    @(posedge clk); #1;
    do_reset(2);
    n_vec++;
    if (fifo_level !== 3'd0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_settle_discard: level %0d valid %b, expected 0 0", fifo_level, out_valid);
    end
    run_neuron(2 * ONE, ONE / 4, 1'b0, 8'd2, L + 2);
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    run_neuron(10 * ONE, 0, 1'b0, 8'd10, L + 2);
    run_neuron(-7 * ONE, 0, 1'b0, 8'hF9, L + 2);
    acc_in   = 26'(20 * ONE);
    bias_in  = '0;
    relu_en  = 1'b0;
    acc_done = 1'b1;
    exp_q.push_back(8'd20);
    repeat (L + 1) @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (fifo_level !== 3'd2 || mac_rst !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_before: level %0d mac_rst %b, expected 2 0", fifo_level, mac_rst);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    n_vec++;
    if (fifo_level !== 3'd2 || mac_rst !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_after: level %0d mac_rst %b, expected 2 1", fifo_level, mac_rst);
    end
    @(posedge clk); #1;
    acc_done = 1'b0;
    drain();
  endtask

  initial begin
    rst       = 1'b1;
    acc_in    = '0;
    bias_in   = '0;
    acc_done  = 1'b0;
    relu_en   = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_relu_round();
    test_saturation();
    test_backpressure();
    test_reset_settle();
    test_back_to_back();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover: %0d pending, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
